// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: frame FSM states, prefix bytes,
// consumer-facing scan codes and the frame validity check.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_t;

   localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
   localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

   localparam logic [7:0] PS2_KEY_ESC   = 8'h76;
   localparam logic [7:0] PS2_KEY_S     = 8'h1B;
   localparam logic [7:0] PS2_KEY_P     = 8'h4D;
   localparam logic [7:0] PS2_KEY_R     = 8'h2D;
   localparam logic [7:0] PS2_KEY_UP    = 8'h75;
   localparam logic [7:0] PS2_KEY_DOWN  = 8'h72;
   localparam logic [7:0] PS2_KEY_LEFT  = 8'h6B;
   localparam logic [7:0] PS2_KEY_RIGHT = 8'h74;

   // A frame is good when the stop bit is high and data plus parity has odd weight.
   function automatic logic frame_ok(input logic [7:0] data, input logic parity,
                                     input logic stop);
      return stop & (^{data, parity});
   endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Two-flop synchronizer followed by a stability filter: the output only
// follows the pin after FILTER_LEN consecutive cycles at the new level.
module ps2_input_filter
   import ps2_pkg::*;
#(
   parameter int   FILTER_LEN = 4,
   parameter logic RST_VAL    = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic          meta_r;
   logic          sync_r;
   logic          level_r;
   logic [CW-1:0] cnt_r;

   // Synchronize the pin and adopt a new level only after it has held long enough.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_r  <= 1'b0;
         sync_r  <= 1'b0;
         level_r <= RST_VAL;
         cnt_r   <= '0;
      end else begin
         meta_r <= din;
         sync_r <= meta_r;
         if (sync_r != level_r) begin
            if (cnt_r == CW'(FILTER_LEN - 1)) begin
               level_r <= sync_r;
               cnt_r   <= '0;
            end else begin
               cnt_r <= cnt_r + CW'(1);
            end
         end else begin
            cnt_r <= '0;
         end
      end
   end

   assign dout = level_r;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 keyboard receiver: filtered pins, 11-bit frame FSM with timeout,
// and a key decoder that folds E0/F0 prefixes into flags on the key event.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       PS2_CLK,
   input  logic       PS2_DAT,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_err,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_release,
   output logic       key_valid
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          ps2_clk_f_s;
   logic          ps2_dat_f_s;
   logic          clk_prev_r;
   logic          fall_s;
   ps2_state_t    state_r;
   ps2_state_t    state_nxt_s;
   logic [2:0]    bit_cnt_r;
   logic [7:0]    shift_r;
   logic          parity_r;
   logic [TW-1:0] to_cnt_r;
   logic          timeout_s;
   logic          good_s;
   logic          bad_s;
   logic          ext_pend_r;
   logic          rel_pend_r;

   ps2_input_filter #(.FILTER_LEN(FILTER_LEN), .RST_VAL(1'b1)) u_clk_filter (
      .clk  (clk),
      .rst  (rst),
      .din  (PS2_CLK),
      .dout (ps2_clk_f_s)
   );

   ps2_input_filter #(.FILTER_LEN(FILTER_LEN), .RST_VAL(1'b1)) u_dat_filter (
      .clk  (clk),
      .rst  (rst),
      .din  (PS2_DAT),
      .dout (ps2_dat_f_s)
   );

   assign fall_s    = clk_prev_r & ~ps2_clk_f_s;
   // A fall in the same cycle always beats the timeout.
   assign timeout_s = (state_r != IDLE) && !fall_s && (to_cnt_r == TW'(TIMEOUT_CYCLES - 1));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (fall_s && !ps2_dat_f_s) begin
               state_nxt_s = DATA;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         DATA: begin
            if (fall_s && (bit_cnt_r == 3'd7)) begin
               state_nxt_s = PARITY;
            end else begin
               state_nxt_s = DATA;
            end
         end
         PARITY: begin
            if (fall_s) begin
               state_nxt_s = STOP;
            end else begin
               state_nxt_s = PARITY;
            end
         end
         STOP: begin
            if (fall_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = STOP;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
      if (timeout_s) begin
         state_nxt_s = IDLE;
      end else begin
         state_nxt_s = state_nxt_s;
      end
   end

   // Frame completion decode.
   always_comb begin
      good_s = 1'b0;
      bad_s  = timeout_s;
      if ((state_r == STOP) && fall_s) begin
         good_s = frame_ok(shift_r, parity_r, ps2_dat_f_s);
         bad_s  = ~frame_ok(shift_r, parity_r, ps2_dat_f_s);
      end else begin
         good_s = 1'b0;
      end
   end

   // Edge history, bit shifter and inter-edge timeout counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_prev_r <= 1'b0;
         bit_cnt_r  <= 3'd0;
         shift_r    <= 8'h00;
         parity_r   <= 1'b0;
         to_cnt_r   <= '0;
      end else begin
         clk_prev_r <= ps2_clk_f_s;
         if (fall_s || (state_r == IDLE) || timeout_s) begin
            to_cnt_r <= '0;
         end else begin
            to_cnt_r <= to_cnt_r + TW'(1);
         end
         if (fall_s) begin
            case (state_r)
               IDLE:    bit_cnt_r <= 3'd0;
               DATA: begin
                  shift_r   <= {ps2_dat_f_s, shift_r[7:1]};
                  bit_cnt_r <= bit_cnt_r + 3'd1;
               end
               PARITY:  parity_r <= ps2_dat_f_s;
               default: bit_cnt_r <= bit_cnt_r;
            endcase
         end
      end
   end

   // Registered frame result pulses and payload.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
         rx_byte  <= 8'h00;
      end else begin
         rx_valid <= good_s;
         rx_err   <= bad_s;
         if (good_s) begin
            rx_byte <= shift_r;
         end
      end
   end

   // Key decoder: prefixes arm flags, the next ordinary byte consumes them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ext_pend_r  <= 1'b0;
         rel_pend_r  <= 1'b0;
         key_code    <= 8'h00;
         key_ext     <= 1'b0;
         key_release <= 1'b0;
         key_valid   <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         if (rx_valid) begin
            if (rx_byte == PS2_EXT_PREFIX) begin
               ext_pend_r <= 1'b1;
            end else if (rx_byte == PS2_BREAK_PREFIX) begin
               rel_pend_r <= 1'b1;
            end else begin
               key_code    <= rx_byte;
               key_ext     <= ext_pend_r;
               key_release <= rel_pend_r;
               key_valid   <= 1'b1;
               ext_pend_r  <= 1'b0;
               rel_pend_r  <= 1'b0;
            end
         end else if (rx_err) begin
            ext_pend_r <= 1'b0;
            rel_pend_r <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Bench for ps2_rx_frame: directed and random PS/2 frames against a
// frame-level reference model compared on every cycle.
module tb_ps2_rx_frame;

   localparam int FL  = 4;
   localparam int TO  = 200;
   localparam int LAT = 3 + FL;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_dat = 1'b1;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_err;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_release;
   logic       key_valid;

   ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .PS2_CLK     (ps2_clk),
      .PS2_DAT     (ps2_dat),
      .rx_byte     (rx_byte),
      .rx_valid    (rx_valid),
      .rx_err      (rx_err),
      .key_code    (key_code),
      .key_ext     (key_ext),
      .key_release (key_release),
      .key_valid   (key_valid)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: result events keyed by the cycle they must appear.
   logic [8:0] exp_rx  [int unsigned];
   logic [9:0] exp_key [int unsigned];
   logic [7:0] m_byte = 8'h00;
   logic [7:0] m_key  = 8'h00;
   logic       m_ext  = 1'b0;
   logic       m_rel  = 1'b0;
   logic       p_ext  = 1'b0;
   logic       p_rel  = 1'b0;
   logic       e_rv, e_re, e_kv;
   logic [8:0] ev;
   int unsigned last_stop_cyc = 0;
   int unsigned last_fall_cyc = 0;
   int unsigned last_rv_cyc   = 0;
   int n_rv = 0;
   int n_err = 0;
   int n_kv = 0;

   always @(posedge clk) begin
      #2;
      if (rst) begin
         exp_rx.delete();
         exp_key.delete();
         m_byte = 8'h00; m_key = 8'h00; m_ext = 1'b0; m_rel = 1'b0;
         p_ext = 1'b0; p_rel = 1'b0;
         chk("reset_outputs", {13'd0, rx_byte, rx_valid, rx_err, key_code, key_ext,
                               key_release, key_valid}, 32'd0);
      end else begin
         e_rv = 1'b0; e_re = 1'b0; e_kv = 1'b0;
         if (exp_key.exists(cyc)) begin
            {m_rel, m_ext, m_key} = exp_key[cyc];
            exp_key.delete(cyc);
            e_kv = 1'b1;
         end
         if (exp_rx.exists(cyc)) begin
            ev = exp_rx[cyc];
            exp_rx.delete(cyc);
            if (ev[8]) begin
               e_rv = 1'b1;
               m_byte = ev[7:0];
               if (ev[7:0] == 8'hE0) p_ext = 1'b1;
               else if (ev[7:0] == 8'hF0) p_rel = 1'b1;
               else begin
                  exp_key[cyc + 1] = {p_rel, p_ext, ev[7:0]};
                  p_ext = 1'b0;
                  p_rel = 1'b0;
               end
            end else begin
               e_re = 1'b1;
               p_ext = 1'b0;
               p_rel = 1'b0;
            end
         end
         chk("rx_valid", 32'(rx_valid), 32'(e_rv));
         chk("rx_err", 32'(rx_err), 32'(e_re));
         chk("rx_byte", 32'(rx_byte), 32'(m_byte));
         chk("key_valid", 32'(key_valid), 32'(e_kv));
         chk("key_code", 32'(key_code), 32'(m_key));
         chk("key_ext", 32'(key_ext), 32'(m_ext));
         chk("key_release", 32'(key_release), 32'(m_rel));
         if (rx_valid) begin last_rv_cyc = cyc; n_rv++; end
         if (rx_err) n_err++;
         if (key_valid) n_kv++;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One 11-bit frame; glitch_bit >= 0 adds a 3-cycle clock dip before that bit's fall.
   task automatic send_frame(input logic [7:0] data, input logic par_flip, input logic stop_bit,
                             input int half, input int glitch_bit);
      logic        par;
      logic [10:0] bits;
      par  = ~(^data) ^ par_flip;
      bits = {stop_bit, par, data, 1'b0};
      for (int i = 0; i < 11; i++) begin
         ps2_dat = bits[i];
         idle(half / 2);
         if (i == glitch_bit) begin
            ps2_clk = 1'b0;
            idle(3);
            ps2_clk = 1'b1;
            idle(half / 2);
         end
         ps2_clk = 1'b0;
         if (i == 10) begin
            last_stop_cyc = cyc;
            exp_rx[cyc + LAT] = {stop_bit & (^{data, par}), data};
         end
         idle(half);
         ps2_clk = 1'b1;
         idle(half - half / 2);
      end
      ps2_dat = 1'b1;
   endtask

   // Start bit plus nbits data bits, then the pins are left idle.
   task automatic send_partial(input logic [7:0] data, input int nbits, input int half);
      logic [8:0] bits;
      bits = {data, 1'b0};
      for (int i = 0; i <= nbits; i++) begin
         ps2_dat = bits[i];
         idle(half / 2);
         ps2_clk = 1'b0;
         last_fall_cyc = cyc;
         idle(half);
         ps2_clk = 1'b1;
         idle(half - half / 2);
      end
      ps2_dat = 1'b1;
   endtask

   int base_rv, base_err, base_kv;
   int half, gl;
   logic [7:0] b;

   initial begin
      @(negedge clk);
      idle(4);
      rst = 1'b0;
      idle(10);

      // Good frame 0x1C with 40-cycle bit period
      send_frame(8'h1C, 1'b0, 1'b1, 20, -1);
      idle(20);
      chk("latency_stop_to_valid", last_rv_cyc - last_stop_cyc, 32'd7);
      chk("lit_rx_byte_1C", 32'(rx_byte), 32'h1C);
      chk("lit_model_byte_1C", 32'(m_byte), 32'h1C);
      chk("lit_key_1C", {22'd0, key_release, key_ext, key_code}, 32'h01C);

      // E0 F0 75 back to back
      base_rv = n_rv; base_kv = n_kv;
      send_frame(8'hE0, 1'b0, 1'b1, 20, -1);
      send_frame(8'hF0, 1'b0, 1'b1, 20, -1);
      send_frame(8'h75, 1'b0, 1'b1, 20, -1);
      idle(20);
      chk("prefix_rv_count", 32'(n_rv - base_rv), 32'd3);
      chk("prefix_kv_count", 32'(n_kv - base_kv), 32'd1);
      chk("lit_key_E0F075", {22'd0, key_release, key_ext, key_code}, 32'h375);
      chk("lit_model_key_E0F075", {22'd0, m_rel, m_ext, m_key}, 32'h375);

      send_frame(8'hF0, 1'b0, 1'b1, 20, -1);
      send_frame(8'h1C, 1'b0, 1'b1, 20, -1);
      idle(20);
      chk("lit_key_F01C", {22'd0, key_release, key_ext, key_code}, 32'h21C);

      // Parity error keeps the previous byte
      send_frame(8'h29, 1'b0, 1'b1, 20, -1);
      base_rv = n_rv; base_err = n_err;
      send_frame(8'h1C, 1'b1, 1'b1, 20, -1);
      idle(20);
      chk("parity_err_count", 32'(n_err - base_err), 32'd1);
      chk("parity_no_valid", 32'(n_rv - base_rv), 32'd0);
      chk("lit_rx_byte_kept", 32'(rx_byte), 32'h29);

      send_frame(8'hE0, 1'b0, 1'b1, 20, -1);
      send_frame(8'h1C, 1'b1, 1'b1, 20, -1);
      send_frame(8'h75, 1'b0, 1'b1, 20, -1);
      idle(20);
      chk("lit_key_ext_cleared", {22'd0, key_release, key_ext, key_code}, 32'h075);

      // Glitches in IDLE and mid-DATA
      ps2_clk = 1'b0; idle(3); ps2_clk = 1'b1;
      idle(15);
      send_frame(8'h16, 1'b0, 1'b1, 20, 3);
      idle(20);
      chk("lit_glitch_byte_16", 32'(rx_byte), 32'h16);

      // Timeout after start + 5 data bits
      base_err = n_err;
      send_partial(8'h55, 5, 20);
      exp_rx[last_fall_cyc + LAT + TO] = 9'h000;
      idle(TO + 40);
      chk("timeout_err_once", 32'(n_err - base_err), 32'd1);
      send_frame(8'h1B, 1'b0, 1'b1, 20, -1);
      idle(20);
      chk("lit_after_timeout_1B", 32'(rx_byte), 32'h1B);

      // Reset mid-frame
      send_partial(8'hA5, 4, 20);
      rst = 1'b1;
      #1;
      chk("reset_immediate", {13'd0, rx_byte, rx_valid, rx_err, key_code, key_ext,
                              key_release, key_valid}, 32'd0);
      idle(4);
      rst = 1'b0;
      idle(10);
      send_frame(8'h76, 1'b0, 1'b1, 20, -1);
      idle(20);
      chk("lit_after_reset_76", {14'd0, key_release, key_ext, key_code, rx_byte}, 32'h07676);

      // Random traffic
      for (int k = 0; k < 60; k++) begin
         gl = $urandom_range(0, 9);
         if (gl < 2) b = 8'hE0;
         else if (gl < 4) b = 8'hF0;
         else b = 8'($urandom_range(0, 255));
         half = $urandom_range(12, 24);
         gl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 10)) : -1;
         send_frame(b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) != 0), half, gl);
         idle($urandom_range(0, 15));
      end

      idle(30);
      chk("events_outstanding", 32'(exp_rx.num() + exp_key.num()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
